// File: rtl/display_output_stage.sv
// Colour-depth reduction (truncate / round / 2x2 Bayer dither) and sync/DE
// alignment pipeline sitting between the timing generator and the pins.
module display_output_stage #(
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 4,
    parameter int LATENCY   = 2,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int TEMPORAL  = 1
) (
    input  logic                 i_pix_clk,
    input  logic                 i_rst,
    input  logic                 i_hs,
    input  logic                 i_vs,
    input  logic                 i_de,
    input  logic                 i_frame,
    input  logic [15:0]          i_sx,
    input  logic [15:0]          i_sy,
    input  logic [IN_DEPTH-1:0]  i_red,
    input  logic [IN_DEPTH-1:0]  i_green,
    input  logic [IN_DEPTH-1:0]  i_blue,
    input  logic [1:0]           i_mode,
    output logic                 o_hs,
    output logic                 o_vs,
    output logic                 o_de,
    output logic [OUT_DEPTH-1:0] o_red,
    output logic [OUT_DEPTH-1:0] o_green,
    output logic [OUT_DEPTH-1:0] o_blue,
    output logic [1:0]           o_mode
);

    localparam int S = IN_DEPTH - OUT_DEPTH;
    localparam int W = 5 + 3 * OUT_DEPTH;
    localparam logic [OUT_DEPTH:0]  MAX       = {1'b0, {OUT_DEPTH{1'b1}}};
    localparam logic [IN_DEPTH:0]   ROUND_ADD = {{IN_DEPTH{1'b0}}, 1'b1} << (S - 1);
    localparam logic                HS_IDLE   = (H_POL == 0) ? 1'b1 : 1'b0;
    localparam logic                VS_IDLE   = (V_POL == 0) ? 1'b1 : 1'b0;
    localparam logic [W-1:0]        PIPE_IDLE = {HS_IDLE, VS_IDLE, {(W-2){1'b0}}};

    typedef enum logic [1:0] {
        MODE_TRUNC  = 2'd0,
        MODE_ROUND  = 2'd1,
        MODE_DITHER = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    // Sums carry one extra bit so the saturation test sees the overflow.
    function automatic logic [OUT_DEPTH-1:0] reduce_chan(
        input logic [IN_DEPTH-1:0] c,
        input mode_e               m,
        input logic [1:0]          t
    );
        logic [IN_DEPTH:0]  add;
        logic [IN_DEPTH:0]  sum;
        logic [OUT_DEPTH:0] q;
        case (m)
            MODE_ROUND:  add = ROUND_ADD;
            MODE_DITHER: add = {{(IN_DEPTH-1){1'b0}}, t} << (S - 2);
            default:     add = '0;
        endcase
        sum = {1'b0, c} + add;
        q   = sum[IN_DEPTH:S];
        return (q > MAX) ? MAX[OUT_DEPTH-1:0] : q[OUT_DEPTH-1:0];
    endfunction

    mode_e             mode_q, mode_d;
    logic [1:0]        fc_q, fc_d;
    logic [1:0]        idx;
    logic [1:0]        thr;
    logic [W-1:0]      pipe_d;
    logic [W-1:0]      pipe_q [LATENCY];
    logic [IN_DEPTH-1:0]  chan_in  [3];
    logic [OUT_DEPTH-1:0] chan_out [3];

    wire unused_coord = ^{i_sx[15:1], i_sy[15:1]};

    assign chan_in[0] = i_red;
    assign chan_in[1] = i_green;
    assign chan_in[2] = i_blue;

    // The strobe pixel already uses the new mode but still the old frame count.
    always_comb begin
        mode_d = mode_q;
        fc_d   = fc_q;
        if (i_frame) begin
            mode_d = (i_mode == MODE_RSVD) ? MODE_TRUNC : mode_e'(i_mode);
            fc_d   = fc_q + 2'd1;
        end
        idx = {i_sy[0], i_sx[0]} ^ ((TEMPORAL != 0) ? fc_q : 2'b00);
        case (idx)
            2'd0:    thr = 2'd0;
            2'd1:    thr = 2'd2;
            2'd2:    thr = 2'd3;
            default: thr = 2'd1;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_out[gi] = reduce_chan(chan_in[gi], mode_d, thr);
        end
    endgenerate

    // Blanking is folded into stage 1 because colour and DE travel together.
    always_comb begin
        pipe_d = {i_hs, i_vs, i_de, mode_d, {(3*OUT_DEPTH){1'b0}}};
        if (i_de) begin
            pipe_d[3*OUT_DEPTH-1:0] = {chan_out[0], chan_out[1], chan_out[2]};
        end
    end

    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            mode_q <= MODE_TRUNC;
            fc_q   <= 2'd0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= PIPE_IDLE;
            end
        end else begin
            mode_q    <= mode_d;
            fc_q      <= fc_d;
            pipe_q[0] <= pipe_d;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign o_hs    = pipe_q[LATENCY-1][W-1];
    assign o_vs    = pipe_q[LATENCY-1][W-2];
    assign o_de    = pipe_q[LATENCY-1][W-3];
    assign o_mode  = pipe_q[LATENCY-1][W-4:W-5];
    assign o_red   = pipe_q[LATENCY-1][3*OUT_DEPTH-1 -: OUT_DEPTH];
    assign o_green = pipe_q[LATENCY-1][2*OUT_DEPTH-1 -: OUT_DEPTH];
    assign o_blue  = pipe_q[LATENCY-1][OUT_DEPTH-1:0];

endmodule

// File: tb/tb_display_output_stage.sv
// Directed bench: three instances (LATENCY 2 temporal, LATENCY 2 static, LATENCY 4)
// share one stimulus bus and are checked against hand-computed values.
module tb_display_output_stage;

    logic        clk = 1'b0;
    logic        rst, hs, vs, de, frame;
    logic [15:0] sx, sy;
    logic [7:0]  red, green, blue;
    logic [1:0]  mode;

    logic       a_hs, a_vs, a_de, b_hs, b_vs, b_de, c_hs, c_vs, c_de;
    logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
    logic [1:0] a_m, b_m, c_m;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_output_stage #(.IN_DEPTH(8), .OUT_DEPTH(4), .LATENCY(2), .H_POL(0), .V_POL(0), .TEMPORAL(1)) dut_a (
        .i_pix_clk(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(frame),
        .i_sx(sx), .i_sy(sy), .i_red(red), .i_green(green), .i_blue(blue), .i_mode(mode),
        .o_hs(a_hs), .o_vs(a_vs), .o_de(a_de), .o_red(a_r), .o_green(a_g), .o_blue(a_b), .o_mode(a_m));

    display_output_stage #(.IN_DEPTH(8), .OUT_DEPTH(4), .LATENCY(2), .H_POL(0), .V_POL(0), .TEMPORAL(0)) dut_b (
        .i_pix_clk(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(frame),
        .i_sx(sx), .i_sy(sy), .i_red(red), .i_green(green), .i_blue(blue), .i_mode(mode),
        .o_hs(b_hs), .o_vs(b_vs), .o_de(b_de), .o_red(b_r), .o_green(b_g), .o_blue(b_b), .o_mode(b_m));

    display_output_stage #(.IN_DEPTH(8), .OUT_DEPTH(4), .LATENCY(4), .H_POL(0), .V_POL(0), .TEMPORAL(1)) dut_c (
        .i_pix_clk(clk), .i_rst(rst), .i_hs(hs), .i_vs(vs), .i_de(de), .i_frame(frame),
        .i_sx(sx), .i_sy(sy), .i_red(red), .i_green(green), .i_blue(blue), .i_mode(mode),
        .o_hs(c_hs), .o_vs(c_vs), .o_de(c_de), .o_red(c_r), .o_green(c_g), .o_blue(c_b), .o_mode(c_m));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic [1:0] m, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input logic x, input logic y);
        frame = f; mode = m; red = r; green = g; blue = b;
        sx = {15'd0, x}; sy = {15'd0, y};
    endtask

    // got/exp layout: {hs, vs, de, red, green, blue, mode}
    task automatic test_reset();
        logic [16:0] got, exp;
        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b1;
        drive(1'b0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            got = {a_hs, a_vs, a_de, a_r, a_g, a_b, a_m};
            exp = {3'b110, 12'h000, 2'd0};
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL reset_hold[%0d]: got %h required %h", i, got, exp); end
        end
        rst = 1'b0;
        tick();
        got = {a_hs, a_vs, a_de, a_r, a_g, a_b, a_m};
        exp = {3'b110, 12'h000, 2'd0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_release_1: got %h required %h", got, exp); end
        tick();
        got = {a_hs, a_vs, a_de, a_r, a_g, a_b, a_m};
        exp = {3'b001, 12'hFFF, 2'd0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL reset_first_pixel: got %h required %h", got, exp); end
        $display("test_reset done");
    endtask

    task automatic test_truncate();
        logic [13:0] got, exp;
        hs = 1'b1; vs = 1'b1; de = 1'b1;
        drive(1'b1, 2'd0, 8'hAB, 8'h0F, 8'h10, 1'b0, 1'b0);
        tick();
        frame = 1'b0;
        tick();
        got = {a_r, a_g, a_b, a_m};
        exp = {12'hA01, 2'd0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL truncate: got %h required %h", got, exp); end
        $display("test_truncate done");
    endtask

    task automatic test_round();
        logic [13:0] got, exp;
        drive(1'b1, 2'd1, 8'hA8, 8'hA7, 8'hF8, 1'b0, 1'b0);
        tick();
        frame = 1'b0;
        tick();
        got = {a_r, a_g, a_b, a_m};
        exp = {12'hBAF, 2'd1};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL round_sat: got %h required %h", got, exp); end
        $display("test_round done");
    endtask

    // fc is 2 at the dither strobe (two strobes so far), 3 afterwards.
    task automatic test_dither();
        logic [1:0]  vx  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  vy  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0]  ea  [4] = '{4'h5, 4'h4, 4'h5, 4'h4};
        logic [3:0]  eb  [4] = '{4'h4, 4'h4, 4'h4, 4'h5};
        logic [13:0] got, exp;
        for (int i = 0; i < 4; i++) begin
            drive((i == 0), 2'd2, 8'h45, 8'h45, 8'h45, vx[i][0], vy[i][0]);
            tick();
            frame = 1'b0;
            tick();
            got = {b_r, b_g, b_b, b_m};
            exp = {eb[i], eb[i], eb[i], 2'd2};
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL dither_static[%0d]: got %h required %h", i, got, exp); end
            got = {a_r, a_g, a_b, a_m};
            exp = {ea[i], ea[i], ea[i], 2'd2};
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL dither_temporal[%0d]: got %h required %h", i, got, exp); end
        end
        $display("test_dither done");
    endtask

    task automatic test_mode_timing();
        logic [5:0] got, exp;
        drive(1'b1, 2'd0, 8'hA8, 8'hA8, 8'hA8, 1'b0, 1'b0);
        tick();
        frame = 1'b0; mode = 2'd1;
        tick();
        tick();
        got = {a_r, a_m}; exp = {4'hA, 2'd0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL mode_ignored_midframe: got %h required %h", got, exp); end
        frame = 1'b1;
        tick();
        frame = 1'b0;
        got = {a_r, a_m}; exp = {4'hA, 2'd0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL mode_before_strobe: got %h required %h", got, exp); end
        tick();
        got = {a_r, a_m}; exp = {4'hB, 2'd1};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL mode_at_strobe: got %h required %h", got, exp); end
        frame = 1'b1; mode = 2'd3;
        tick();
        frame = 1'b0;
        tick();
        got = {a_r, a_m}; exp = {4'hA, 2'd0};
        n_cmp++;
        if (got !== exp) begin n_bad++; $display("FAIL mode_reserved: got %h required %h", got, exp); end
        $display("test_mode_timing done");
    endtask

    task automatic test_blank_align();
        logic [14:0] got, exp;
        hs = 1'b1; vs = 1'b1; de = 1'b0;
        drive(1'b0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        hs = 1'b0; vs = 1'b0; de = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            hs = 1'b1; vs = 1'b1; de = 1'b0;
            got = {c_hs, c_vs, c_de, c_r, c_g, c_b};
            exp = (k == 4) ? {3'b001, 12'hFFF} : {3'b110, 12'h000};
            n_cmp++;
            if (got !== exp) begin n_bad++; $display("FAIL align_lat4[k=%0d]: got %h required %h", k, got, exp); end
            if (k == 2 || k == 3) begin
                got = {a_hs, a_vs, a_de, a_r, a_g, a_b};
                exp = (k == 2) ? {3'b001, 12'hFFF} : {3'b110, 12'h000};
                n_cmp++;
                if (got !== exp) begin n_bad++; $display("FAIL align_lat2[k=%0d]: got %h required %h", k, got, exp); end
            end
        end
        $display("test_blank_align done");
    endtask

    task automatic test_reset_midflight();
        logic [2:0] got;
        de = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; de = 1'b0;
        got = {a_de, c_de, |a_r};
        n_cmp++;
        if (got !== 3'b000) begin n_bad++; $display("FAIL midflight_reset: got %b required 000", got); end
        tick();
        got = {a_de, c_de, |a_r};
        n_cmp++;
        if (got !== 3'b000) begin n_bad++; $display("FAIL midflight_discard: got %b required 000", got); end
        $display("test_reset_midflight done");
    endtask

    initial begin
        test_reset();
        test_truncate();
        test_round();
        test_dither();
        test_mode_timing();
        test_blank_align();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_output_stage.md
Name: display_output_stage

Overview:
- Parametrised VGA/DVI output stage between display_timings plus a test card and the board pins.
- Reduces IN_DEPTH-bit colour to OUT_DEPTH bits by one of three modes: truncate, round-to-nearest with saturation, or ordered 2x2 Bayer dither with optional temporal rotation.
- Delays sync and DE by the same configurable latency as colour so every output stays aligned.
- Blanks colour outside DE. The selected mode changes only at frame start, so a frame never tears.

Parameters:
- IN_DEPTH, 8, input bits per colour channel.
- OUT_DEPTH, 4, output bits per colour channel. IN_DEPTH-OUT_DEPTH must be >= 2.
- LATENCY, 2, pipeline stages from input to output. Must be >= 1.
- H_POL, 0, hsync active level. The inactive level is ~H_POL.
- V_POL, 0, vsync active level.
- TEMPORAL, 1, when 1 the Bayer index is rotated by a 2-bit frame counter.

Ports:
- i_pix_clk  in  1  pixel clock
- i_rst  in  1  synchronous active-high reset
- i_hs  in  1  horizontal sync from timings
- i_vs  in  1  vertical sync from timings
- i_de  in  1  display enable
- i_frame  in  1  one-cycle frame-start strobe
- i_sx  in  16  signed screen x; only bit 0 is used
- i_sy  in  16  signed screen y; only bit 0 is used
- i_red  in  IN_DEPTH  red
- i_green  in  IN_DEPTH  green
- i_blue  in  IN_DEPTH  blue
- i_mode  in  2  requested mode: 0 truncate, 1 round, 2 dither, 3 reserved (behaves as truncate)
- o_hs  out  1  delayed hsync
- o_vs  out  1  delayed vsync
- o_de  out  1  delayed DE
- o_red  out  OUT_DEPTH  reduced red
- o_green  out  OUT_DEPTH  reduced green
- o_blue  out  OUT_DEPTH  reduced blue
- o_mode  out  2  mode currently in effect

Behaviour:
- Definitions: S = IN_DEPTH-OUT_DEPTH; MAX = 2^OUT_DEPTH-1.
- Reset: synchronous on i_pix_clk while i_rst=1. It clears every pipeline stage.
  - o_hs=~H_POL, o_vs=~V_POL, o_de=0, colours 0, o_mode=0.
  - Frame counter fc=0.
  - Outputs hold these values for LATENCY cycles after reset deasserts, until real data emerges.
  - Reset mid-frame discards all in-flight pixels.
- Mode register:
  - On a cycle with i_frame=1, the active mode is loaded from i_mode (3 maps to 0), and that pixel already uses the new mode.
  - i_mode changes on any other cycle are ignored.
  - o_mode shows the active mode, delayed LATENCY cycles so it aligns with the pixel that used it.
- Frame counter: fc is 2 bits and increments on each i_frame=1, wrapping 3->0. It increments after the current pixel's index has been computed, so the i_frame pixel uses the old fc.
- Bayer index: idx = {sy[0],sx[0]}, XORed with fc when TEMPORAL=1. Threshold t: idx0=0, idx1=2, idx2=3, idx3=1.
- Per-channel reduction, using c = the input channel:
  - Truncate: c[IN_DEPTH-1:S].
  - Round: (c + 2^(S-1)) >> S; if the result exceeds MAX, output MAX.
  - Dither: (c + (t << (S-2))) >> S, saturated to MAX the same way.
  - The sums are computed in IN_DEPTH+1 bits, so none of them wraps.
- Pipeline: stage 1 registers the reduced colours plus hs, vs, de and mode. Stages 2..LATENCY are plain delay registers. Input-to-output latency is exactly LATENCY cycles for all outputs.
- Blanking: output colour = 0 whenever the delayed de = 0, whatever the input colour.
- Bubbles: none. A new pixel is accepted every cycle and there is no backpressure.

Test Plan:
- Reset, LATENCY=2: hold i_rst=1 for 3 cycles with hs=vs=0, i_de=1, colours 0xFF, then release.
  - Required: during reset o_hs=1, o_vs=1, o_de=0, colours 0.
  - Required: the first real pixel appears exactly 2 cycles after release, as 0xF with o_de=1.
- Truncate, mode 0 latched by i_frame: input red=0xAB, green=0x0F, blue=0x10, i_de=1 -> o_red=0xA, o_green=0x0, o_blue=0x1, 2 cycles later.
- Round, mode 1: red=0xA8 -> 0xB; green=0xA7 -> 0xA; blue=0xF8 -> 0xF (saturated, not 0x0).
- Dither, mode 2, TEMPORAL=0, all channels 0x45:
  - (sx,sy)=(0,0) -> 0x4; (1,0) t=2 -> 0x4; (0,1) t=3 -> 0x5.
  - With TEMPORAL=1, after 3 i_frame strobes (fc=3), pixel (0,0) uses t=1 and outputs 0x4.
- Mode timing: i_mode goes 0->1 mid-frame with input 0xA8.
  - Required: outputs stay truncated (0xA) and o_mode=0 until the pixel arriving with i_frame=1, which outputs 0xB with o_mode=1.
  - Required: i_mode=3 latched at frame start gives o_mode=0 and truncate output.
- Blanking and alignment, LATENCY=4: a pulse on i_hs, i_vs and i_de with colour 0xFF, de low elsewhere.
  - Required: o_hs, o_vs and o_de each move exactly 4 cycles later.
  - Required: colour is 0xF only while o_de=1, and 0 everywhere else.
